// File: rtl/pim_conv_scheduler_if.sv
// Handshake and PIM bus bundle for pim_conv_scheduler.
// The scheduler uses the master modport; the upstream, PIM and downstream side uses slave.
interface pim_conv_scheduler_if #(
  parameter int DATA_W = 6,
  parameter int TAPS   = 25,
  parameter int ADDR_W = 5,
  parameter int RES_W  = 18
);
  logic                     win_valid;
  logic                     win_ready;
  logic [DATA_W*TAPS-1:0]   win_data;
  logic [DATA_W*TAPS-1:0]   pim_in_data;
  logic [ADDR_W-1:0]        pim_addr;
  logic                     pim_en;
  logic [RES_W-1:0]         pim_result;
  logic                     out_valid;
  logic                     out_ready;
  logic [RES_W-1:0]         out_data;
  logic [ADDR_W-1:0]        out_addr;
  logic                     out_last;
  logic                     frame_done;
  logic                     busy;

  modport master (
    input  win_valid, win_data, pim_result, out_ready,
    output win_ready, pim_in_data, pim_addr, pim_en, out_valid,
           out_data, out_addr, out_last, frame_done, busy
  );

  modport slave (
    output win_valid, win_data, pim_result, out_ready,
    input  win_ready, pim_in_data, pim_addr, pim_en, out_valid,
           out_data, out_addr, out_last, frame_done, busy
  );
endinterface

// File: rtl/pim_conv_scheduler.sv
// Sequencer for the 5x5 PIM convolution unit: holds one window on the PIM taps,
// sweeps every kernel address, streams tagged results and flags end of frame.
module pim_conv_scheduler #(
  parameter int DATA_W   = 6,
  parameter int TAPS     = 25,
  parameter int ADDR_W   = 5,
  parameter int NUM_ADDR = 6,
  parameter int PIM_LAT  = 1,
  parameter int RES_W    = 18,
  parameter int NUM_WIN  = 576
) (
  input  logic                 clk,
  input  logic                 rst,
  pim_conv_scheduler_if.master bus
);

  localparam int WIN_W  = DATA_W * TAPS;
  localparam int CNT_W  = (PIM_LAT > 1) ? $clog2(PIM_LAT) : 1;
  localparam int WCNT_W = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ADDR - 1);
  localparam logic [CNT_W-1:0]  LAT_LOAD  = CNT_W'(PIM_LAT - 1);
  localparam logic [WCNT_W-1:0] LAST_WIN  = WCNT_W'(NUM_WIN - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUT
  } state_e;

  state_e              state_q,      state_d;
  logic [WIN_W-1:0]    win_q,        win_d;
  logic [ADDR_W-1:0]   addr_q,       addr_d;
  logic [CNT_W-1:0]    cnt_q,        cnt_d;
  logic [WCNT_W-1:0]   wcnt_q,       wcnt_d;
  logic                pim_en_q,     pim_en_d;
  logic                out_valid_q,  out_valid_d;
  logic [RES_W-1:0]    out_data_q,   out_data_d;
  logic [ADDR_W-1:0]   out_addr_q,   out_addr_d;
  logic                out_last_q,   out_last_d;
  logic                frame_done_q, frame_done_d;

  logic win_ready;

  assign win_ready = (state_q == IDLE) && !rst;

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    wcnt_d       = wcnt_q;
    out_data_d   = out_data_q;
    out_addr_d   = out_addr_q;
    out_last_d   = out_last_q;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.win_valid && win_ready) begin
          win_d   = bus.win_data;
          addr_d  = '0;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        cnt_d   = LAT_LOAD;
        state_d = WAIT;
      end

      // pim_result is sampled only in the cycle the latency counter expires
      WAIT: begin
        if (cnt_q == '0) begin
          out_data_d = bus.pim_result;
          out_addr_d = addr_q;
          out_last_d = (addr_q == LAST_ADDR);
          state_d    = OUT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      OUT: begin
        if (bus.out_ready) begin
          if (addr_q < LAST_ADDR) begin
            addr_d  = addr_q + 1'b1;
            state_d = ISSUE;
          end else begin
            state_d      = IDLE;
            frame_done_d = (wcnt_q == LAST_WIN);
            wcnt_d       = (wcnt_q == LAST_WIN) ? '0 : wcnt_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Strobes follow the next state so they are flop outputs aligned with it
    pim_en_d    = (state_d == ISSUE);
    out_valid_d = (state_d == OUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      win_q        <= '0;
      addr_q       <= '0;
      cnt_q        <= '0;
      wcnt_q       <= '0;
      pim_en_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_addr_q   <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      wcnt_q       <= wcnt_d;
      pim_en_q     <= pim_en_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_addr_q   <= out_addr_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.win_ready   = win_ready;
  assign bus.busy        = (state_q != IDLE);
  assign bus.pim_in_data = win_q;
  assign bus.pim_addr    = addr_q;
  assign bus.pim_en      = pim_en_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_addr    = out_addr_q;
  assign bus.out_last    = out_last_q;
  assign bus.frame_done  = frame_done_q;

endmodule

// File: tb/tb_pim_conv_scheduler.sv
// Scoreboard bench for pim_conv_scheduler: two configurations side by side, a PIM
// model with latency and garbage outside the valid cycle, and a per-cycle monitor.
`timescale 1ns/1ps
module tb_pim_conv_scheduler;

  localparam int DW = 6, TAPS = 25, AW = 5, RW = 18, WW = DW * TAPS;
  localparam int NA0 = 6, LAT0 = 1, NW0 = 4;
  localparam int NA1 = 1, LAT1 = 3, NW1 = 1;
  localparam int MAXLAT = 3;

  typedef struct packed {
    logic [RW-1:0] data;
    logic [AW-1:0] addr;
    logic          last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-DUT stimulus / observation arrays (index 0 and 1)
  logic          win_valid [2];
  logic [WW-1:0] win_data [2];
  logic          out_ready [2];
  logic [RW-1:0] pim_result [2];
  logic          win_ready [2], pim_en [2], out_valid [2], out_last [2], frame_done [2], busy [2];
  logic [WW-1:0] pim_in_data [2];
  logic [AW-1:0] pim_addr [2], out_addr [2];
  logic [RW-1:0] out_data [2];

  pim_conv_scheduler_if #(.DATA_W(DW), .TAPS(TAPS), .ADDR_W(AW), .RES_W(RW)) bus0 ();
  pim_conv_scheduler_if #(.DATA_W(DW), .TAPS(TAPS), .ADDR_W(AW), .RES_W(RW)) bus1 ();

  pim_conv_scheduler #(
    .DATA_W(DW), .TAPS(TAPS), .ADDR_W(AW), .NUM_ADDR(NA0),
    .PIM_LAT(LAT0), .RES_W(RW), .NUM_WIN(NW0)
  ) u_dut0 (.clk(clk), .rst(rst), .bus(bus0.master));

  pim_conv_scheduler #(
    .DATA_W(DW), .TAPS(TAPS), .ADDR_W(AW), .NUM_ADDR(NA1),
    .PIM_LAT(LAT1), .RES_W(RW), .NUM_WIN(NW1)
  ) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.master));

  assign bus0.win_valid  = win_valid[0];
  assign bus0.win_data   = win_data[0];
  assign bus0.out_ready  = out_ready[0];
  assign bus0.pim_result = pim_result[0];
  assign bus1.win_valid  = win_valid[1];
  assign bus1.win_data   = win_data[1];
  assign bus1.out_ready  = out_ready[1];
  assign bus1.pim_result = pim_result[1];

  assign win_ready[0]   = bus0.win_ready;
  assign pim_in_data[0] = bus0.pim_in_data;
  assign pim_addr[0]    = bus0.pim_addr;
  assign pim_en[0]      = bus0.pim_en;
  assign out_valid[0]   = bus0.out_valid;
  assign out_data[0]    = bus0.out_data;
  assign out_addr[0]    = bus0.out_addr;
  assign out_last[0]    = bus0.out_last;
  assign frame_done[0]  = bus0.frame_done;
  assign busy[0]        = bus0.busy;
  assign win_ready[1]   = bus1.win_ready;
  assign pim_in_data[1] = bus1.pim_in_data;
  assign pim_addr[1]    = bus1.pim_addr;
  assign pim_en[1]      = bus1.pim_en;
  assign out_valid[1]   = bus1.out_valid;
  assign out_data[1]    = bus1.out_data;
  assign out_addr[1]    = bus1.out_addr;
  assign out_last[1]    = bus1.out_last;
  assign frame_done[1]  = bus1.frame_done;
  assign busy[1]        = bus1.busy;

  function automatic int na(input int i);  return (i == 0) ? NA0  : NA1;  endfunction
  function automatic int lat(input int i); return (i == 0) ? LAT0 : LAT1; endfunction
  function automatic int nw(input int i);  return (i == 0) ? NW0  : NW1;  endfunction

  // What the PIM computes for a window and kernel address (arbitrary but address-dependent)
  function automatic logic [RW-1:0] pim_fn(input logic [WW-1:0] w, input int unsigned a);
    int unsigned s = a;
    for (int unsigned t = 0; t < TAPS; t++)
      s += int'(w[t*DW +: DW]) * ((a * 7 + t) % 13 + 1);
    return RW'(s);
  endfunction

  function automatic logic [WW-1:0] rand_win();
    logic [WW-1:0] w;
    for (int t = 0; t < TAPS; t++) w[t*DW +: DW] = DW'($urandom);
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard
  exp_t q0[$], q1[$];
  int   wdone [2];
  bit   fd_exp [2];
  int   fd_cnt [2];

  function automatic int qsize(input int i); return (i == 0) ? q0.size() : q1.size(); endfunction
  function automatic exp_t qhead(input int i); return (i == 0) ? q0[0] : q1[0]; endfunction
  function automatic exp_t qpop(input int i);
    if (i == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction
  task automatic qpush(input int i, input exp_t e);
    if (i == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // PIM model: result valid exactly PIM_LAT cycles after pim_en, random otherwise
  logic [RW:0] pend [2];
  logic [RW:0] hist [2][MAXLAT];

  always @(negedge clk)
    for (int i = 0; i < 2; i++) pend[i] = {pim_en[i], pim_fn(pim_in_data[i], pim_addr[i])};

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      for (int k = MAXLAT - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
      hist[i][0] = pend[i];
      pim_result[i] = hist[i][lat(i)-1][RW] ? hist[i][lat(i)-1][RW-1:0] : RW'($urandom);
    end
  end

  // Monitor
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        exp_t e;
        check($sformatf("dut%0d frame_done", i), frame_done[i], fd_exp[i]);
        fd_exp[i] = 1'b0;
        if (frame_done[i]) fd_cnt[i]++;
        check($sformatf("dut%0d win_ready vs busy", i), win_ready[i], !busy[i]);
        if (pim_en[i]) begin
          check($sformatf("dut%0d pim_en while out_valid", i), out_valid[i], 0);
          if (qsize(i) == 0) check($sformatf("dut%0d pim_en with no window", i), pim_en[i], 0);
          else check($sformatf("dut%0d pim_addr", i), pim_addr[i], qhead(i).addr);
        end
        if (out_valid[i]) begin
          if (qsize(i) == 0) begin
            check($sformatf("dut%0d unexpected out_valid", i), out_valid[i], 0);
          end else begin
            e = qhead(i);
            check($sformatf("dut%0d out_data", i), out_data[i], e.data);
            check($sformatf("dut%0d out_addr", i), out_addr[i], e.addr);
            check($sformatf("dut%0d out_last", i), out_last[i], e.last);
            if (out_ready[i]) begin
              e = qpop(i);
              if (e.last) begin
                wdone[i]++;
                if (wdone[i] % nw(i) == 0) fd_exp[i] = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int i, input logic [WW-1:0] w, input bit hold, output int unsigned acc);
    int unsigned k = 0;
    win_valid[i] = 1'b1;
    win_data[i]  = w;
    while (!win_ready[i] && k < 500) begin step(); k++; end
    check($sformatf("dut%0d window accepted in bound", i), win_ready[i], 1);
    acc = cyc;
    for (int a = 0; a < na(i); a++)
      qpush(i, '{data: pim_fn(w, a), addr: AW'(a), last: (a == na(i) - 1)});
    step();
    if (!hold) win_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, output int unsigned c);
    int unsigned k = 0;
    while (!win_ready[i] && k < 1000) begin step(); k++; end
    check($sformatf("dut%0d idle in bound", i), win_ready[i], 1);
    c = cyc;
  endtask

  task automatic check_reset(input int i, input string tag);
    check($sformatf("%s dut%0d win_ready", tag, i),   win_ready[i], 0);
    check($sformatf("%s dut%0d pim_in_data", tag, i), |pim_in_data[i], 0);
    check($sformatf("%s dut%0d pim_addr", tag, i),    pim_addr[i], 0);
    check($sformatf("%s dut%0d pim_en", tag, i),      pim_en[i], 0);
    check($sformatf("%s dut%0d out_valid", tag, i),   out_valid[i], 0);
    check($sformatf("%s dut%0d out_data", tag, i),    out_data[i], 0);
    check($sformatf("%s dut%0d out_addr", tag, i),    out_addr[i], 0);
    check($sformatf("%s dut%0d out_last", tag, i),    out_last[i], 0);
    check($sformatf("%s dut%0d frame_done", tag, i),  frame_done[i], 0);
    check($sformatf("%s dut%0d busy", tag, i),        busy[i], 0);
  endtask

  // Cycle-exact schedule with out_ready high: address k issues at 1+k*(2+L), presents at (k+1)*(2+L)
  task automatic timing_run(input int i);
    int unsigned acc, per, k, r, tot;
    send(i, rand_win(), 1'b0, acc);
    per = 2 + lat(i);
    tot = na(i) * per;
    for (int unsigned d = 1; d <= tot + 1; d++) begin
      k = (d - 1) / per;
      r = (d - 1) % per;
      check($sformatf("dut%0d pim_en @+%0d", i, d), pim_en[i], (k < na(i)) && (r == 0));
      check($sformatf("dut%0d out_valid @+%0d", i, d), out_valid[i], (k < na(i)) && (r == per - 1));
      check($sformatf("dut%0d out_last @+%0d", i, d), out_last[i] && out_valid[i], d == tot);
      check($sformatf("dut%0d win_ready @+%0d", i, d), win_ready[i], d == tot + 1);
      step();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc, c, k, fd_base;
    bit rnd_on;
    for (int i = 0; i < 2; i++) begin
      win_valid[i] = 1'b0; win_data[i] = '0; out_ready[i] = 1'b1; pim_result[i] = '0;
      pend[i] = '0; wdone[i] = 0; fd_exp[i] = 1'b0; fd_cnt[i] = 0;
      for (int j = 0; j < MAXLAT; j++) hist[i][j] = '0;
    end
    #1 rst = 1'b1;
    #1;
    check_reset(0, "por");
    check_reset(1, "por");
    repeat (3) step();
    rst = 1'b0;
    #1;
    check("win_ready after release", win_ready[0], 1);
    step();

    // Unstalled sweep of all six kernels
    timing_run(0);

    // Four stall cycles on address 2
    send(0, rand_win(), 1'b0, acc);
    k = 0;
    while (!(out_valid[0] && out_addr[0] == AW'(2)) && k < 100) begin step(); k++; end
    out_ready[0] = 1'b0;
    repeat (4) begin
      check("stall no pim_en", pim_en[0], 0);
      check("stall out_addr held", out_addr[0], 2);
      step();
    end
    out_ready[0] = 1'b1;
    wait_idle(0, c);
    check("stall window latency", c - acc, NA0 * (2 + LAT0) + 1 + 4);

    // Abort during WAIT of address 3
    send(0, rand_win(), 1'b0, acc);
    k = 0;
    while (!(pim_en[0] && pim_addr[0] == AW'(3)) && k < 100) begin step(); k++; end
    step();
    check("busy before abort", busy[0], 1);
    rst = 1'b1;
    #1;
    check_reset(0, "abort");
    q0.delete(); q1.delete();
    for (int i = 0; i < 2; i++) begin wdone[i] = 0; fd_exp[i] = 1'b0; end
    repeat (2) step();
    rst = 1'b0;
    step();

    // Five back-to-back windows with win_valid held across busy periods
    fd_base = fd_cnt[0];
    for (int n = 0; n < 5; n++) send(0, rand_win(), n < 4, acc);
    wait_idle(0, c);
    repeat (2) step();
    check("frame_done pulses over 5 windows", fd_cnt[0] - fd_base, 1);

    // Single-kernel, latency-3 configuration
    fd_base = fd_cnt[1];
    for (int n = 0; n < 3; n++) timing_run(1);
    repeat (2) step();
    check("dut1 frame_done per window", fd_cnt[1] - fd_base, 3);

    // Random windows, gaps and backpressure on both configurations
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          step();
          for (int i = 0; i < 2; i++) out_ready[i] = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        fork
          begin
            int unsigned a0, g0, c0;
            for (int n = 0; n < 20; n++) begin
              g0 = $urandom_range(0, 2);
              send(0, rand_win(), g0 == 0, a0);
              repeat (g0) step();
            end
            win_valid[0] = 1'b0;
            wait_idle(0, c0);
          end
          begin
            int unsigned a1, g1, c1;
            for (int n = 0; n < 20; n++) begin
              g1 = $urandom_range(0, 2);
              send(1, rand_win(), g1 == 0, a1);
              repeat (g1) step();
            end
            win_valid[1] = 1'b0;
            wait_idle(1, c1);
          end
        join
        rnd_on = 1'b0;
      end
    join
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    repeat (3) step();
    check("dut0 scoreboard drained", qsize(0), 0);
    check("dut1 scoreboard drained", qsize(1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pim_conv_scheduler.md
# pim_conv_scheduler

Sequencing controller for the 6-bit 5x5 PIM convolution unit. It accepts one 25-tap input window per handshake and holds it stable on the PIM data bus. It then steps the PIM kernel address through every stored kernel, pulsing the compute enable once per address and capturing each result after a fixed PIM latency. Results go out on a valid/ready stream tagged with kernel address, and the block counts windows to flag end-of-frame to the layer controller.

## Interface
- DATA_W, 6, bits per input tap
- TAPS, 25, taps per window (5x5)
- ADDR_W, 5, width of PIM kernel address
- NUM_ADDR, 6, kernels stored in PIM (addresses 0..NUM_ADDR-1), 1..2^ADDR_W
- PIM_LAT, 1, cycles from pim_en to valid pim_result, >=1
- RES_W, 18, PIM result / output width
- NUM_WIN, 576, windows per frame (24x24 conv1 outputs)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- win_valid  in  1  upstream window valid
- win_ready  out  1  equals (state==IDLE) && !rst
- win_data  in  DATA_W*TAPS  window, tap 0 in LSBs
- pim_in_data  out  DATA_W*TAPS  registered copy of accepted window, drives PIM taps
- pim_addr  out  ADDR_W  current kernel address
- pim_en  out  1  PIM compute enable, one-cycle pulse per address
- pim_result  in  RES_W  PIM output
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- out_data  out  RES_W  captured result
- out_addr  out  ADDR_W  kernel address of out_data
- out_last  out  1  out_addr==NUM_ADDR-1
- frame_done  out  1  one-cycle pulse after last result of window NUM_WIN-1
- busy  out  1  state!=IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - win_ready=1.
  - On win_valid&&win_ready: latch win_data into pim_in_data, set addr=0, go to ISSUE.
  - win_valid while not IDLE is ignored and never acknowledged.
- ISSUE: pim_en=1 for exactly this cycle, pim_addr=addr. Load wait counter with PIM_LAT-1, go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When counter==0, capture pim_result into out_data and addr into out_addr, then go to OUT.
- OUT:
  - out_valid=1. out_data, out_addr and out_last are held stable until out_ready.
  - On out_valid&&out_ready, if addr<NUM_ADDR-1: addr+1, go to ISSUE.
  - On out_valid&&out_ready, otherwise: go to IDLE, increment the window counter, and raise frame_done for the next cycle when the counter was NUM_WIN-1. The window counter wraps to 0.
- pim_in_data and pim_addr stay constant from acceptance until the next accepted window; pim_addr changes only on the OUT->ISSUE step.
- No arithmetic on results; out_data equals pim_result bit-exact at the capture cycle, width RES_W.
- NUM_ADDR=1: one ISSUE/WAIT/OUT pass per window, out_last always 1.
- NUM_WIN=1: frame_done after every window.

## Timing
- Reset values: state IDLE, pim_in_data 0, pim_addr 0, pim_en 0, out_valid 0, out_data 0, out_addr 0, out_last 0, frame_done 0, busy 0, window counter 0. win_ready is 0 while rst is high and 1 the first cycle after release.
- Window accepted in cycle 0: first ISSUE is cycle 1, first capture is cycle 1+PIM_LAT, first out_valid is cycle 2+PIM_LAT.
- Each address costs 2+PIM_LAT cycles with out_ready held high. Each stall cycle of out_ready adds one cycle.
- With out_ready held high, one window takes NUM_ADDR*(2+PIM_LAT) cycles after acceptance. win_ready returns high the cycle after the last output handshake.
- frame_done is high exactly the cycle after the final handshake, coincident with the first IDLE cycle.
- rst mid-operation aborts immediately:
  - The window is dropped and no further pim_en is issued.
  - out_valid drops and the window counter clears.
  - No frame_done is produced.
- A pim_result change outside the capture cycle has no effect.

## Test plan
- NUM_ADDR=6, PIM_LAT=1, out_ready=1, window accepted cycle 0, model PIM returns 100+addr:
  - pim_en is high in cycles 1,4,7,10,13,16 with pim_addr 0..5.
  - out_valid is high in cycles 3,6,...,18 with out_data 100..105.
  - out_last is high only in cycle 18; win_ready returns high in cycle 19.
- Backpressure: out_ready=0 for 4 cycles on addr 2. out_data/out_addr are held, no pim_en is issued during the stall, and total window latency grows by exactly 4 cycles.
- PIM_LAT=3: pim_en cycle c, capture c+3, out_valid c+4. pim_result garbage in cycles c+1..c+2 never appears on out_data.
- NUM_WIN=4: feed 5 windows back-to-back. frame_done pulses once, one cycle after the last handshake of window 4. Window 5 begins a new count; win_valid held during busy is acknowledged only in IDLE.
- Assert rst during WAIT of addr 3: all outputs return to reset values asynchronously. After release, a new window restarts at addr 0 and the window counter restarts from 0.
- NUM_ADDR=1: each window yields exactly one output with out_last=1 and out_addr=0, 3 cycles per window at PIM_LAT=1.
